// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous load, per-digit blink and dp.
// Outputs are registered one cycle behind the digit index; SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// No backpressure: load is a fire-and-forget strobe that is never refused.
module seg7_scan_display #(
    parameter int DIGITS       = 4,
    parameter int DIV_TICKS    = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  load,
    output logic [7:0]            Digitron_Out,
    output logic [DIGITS-1:0]     DigitronCS_Out,
    output logic                  frame_start
);

    localparam int DIV_W = $clog2(DIV_TICKS);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;
    logic                fresh;
    logic [4*DIGITS-1:0] shadow_data;
    logic [4*DIGITS-1:0] disp_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   disp_dp;

    logic                tick;
    logic                frame_end;
    logic [3:0]          nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_blank;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   cs_next;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]   lz;
    logic                zero_run;
`endif

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'h3F;
            4'h1: enc = 7'h06;
            4'h2: enc = 7'h5B;
            4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;
            4'h5: enc = 7'h6D;
            4'h6: enc = 7'h7D;
            4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;
            4'h9: enc = 7'h6F;
            4'hA: enc = 7'h77;
            4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;
            4'hD: enc = 7'h5E;
            4'hE: enc = 7'h79;
            default: enc = 7'h71;
        endcase
    endfunction

    assign tick      = (div_cnt == DIV_W'(DIV_TICKS - 1));
    assign frame_end = tick && (digit_idx == IDX_W'(DIGITS - 1));

    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_blank = 1'b0;
        cs_next   = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // A digit blanks only if it and every digit to its left hold zero.
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
            lz[i]    = zero_run && (i != 0);
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nib        = disp_data[4*i +: 4];
                cur_dp     = disp_dp[i];
                cur_blink  = blink[i];
                cs_next[i] = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                cur_blank  = lz[i];
`endif
            end
        end
        seg_next = {cur_dp, enc(nib)};
        if (cur_blank) begin
            seg_next[6:0] = 7'h00;
        end
        if (blink_phase && cur_blink) begin
            seg_next = 8'h00;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            div_cnt        <= '0;
            digit_idx      <= '0;
            frame_cnt      <= '0;
            blink_phase    <= 1'b0;
            fresh          <= 1'b1;
            shadow_data    <= '0;
            shadow_dp      <= '0;
            disp_data      <= '0;
            disp_dp        <= '0;
            Digitron_Out   <= 8'h00;
            DigitronCS_Out <= '1;
            frame_start    <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            // fresh marks the first cycle of a new index so frame_start fires once per entry to digit 0.
            fresh   <= tick;
            if (tick) begin
                digit_idx <= frame_end ? '0 : digit_idx + IDX_W'(1);
            end
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp;
            end
            if (frame_end) begin
                disp_data <= load ? data : shadow_data;
                disp_dp   <= load ? dp : shadow_dp;
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
            Digitron_Out   <= seg_next;
            DigitronCS_Out <= cs_next;
            frame_start    <= fresh && (digit_idx == '0);
        end
    end

endmodule
